// File: rtl/lpc_io_slave.sv
// LPC I/O-cycle target: decodes I/O read/write frames that fall in a 32-byte window
// and bridges them to a simple register file with one-cycle Rd/Wr strobes.
module lpc_io_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h0A00
) (
    input  logic       LpcClock,
    input  logic       rst,
    input  logic       LFRAME_n,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    output logic [7:0] Addr,
    output logic       Rd,
    output logic       Wr,
    output logic [7:0] DataWr,
    input  logic [7:0] DataRd
);

    typedef enum logic [3:0] {
        IDLE, CYC, ADR3, ADR2, ADR1, ADR0, WDL, WDH,
        HTAR1, HTAR2, SYNC, RDL, RDH, PTAR1, PTAR2
    } state_t;

    state_t      state, state_nxt;
    logic        is_write;
    logic [11:0] addr_hi;   // A[15:4], collected during ADR3..ADR1
    logic [3:0]  wd_lo;
    logic [7:0]  rd_data;
    logic        addr_match;

    assign addr_match = (addr_hi[11:1] == BASE_ADDR[15:5]);

    always_ff @(posedge LpcClock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        Rd        = 1'b0;
        Wr        = 1'b0;
        LAD_oe    = 1'b0;
        LAD_out   = 4'hF;

        if (!LFRAME_n) begin
            state_nxt = (LAD_in == 4'h0) ? CYC : IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                CYC:     state_nxt = (LAD_in == 4'h0 || LAD_in == 4'h2) ? ADR3 : IDLE;
                ADR3:    state_nxt = ADR2;
                ADR2:    state_nxt = ADR1;
                ADR1:    state_nxt = ADR0;
                ADR0:    state_nxt = !addr_match ? IDLE : (is_write ? WDL : HTAR1);
                WDL:     state_nxt = WDH;
                WDH:     state_nxt = HTAR1;
                HTAR1:   state_nxt = HTAR2;
                HTAR2:   state_nxt = SYNC;
                SYNC:    state_nxt = is_write ? PTAR1 : RDL;
                RDL:     state_nxt = RDH;
                RDH:     state_nxt = PTAR1;
                PTAR1:   state_nxt = PTAR2;
                PTAR2:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        // Drive side depends on registered state and data only.
        case (state)
            HTAR1: begin
                Rd = !is_write;
                Wr = is_write;
            end
            SYNC: begin
                LAD_oe  = 1'b1;
                LAD_out = 4'h0;
            end
            RDL: begin
                LAD_oe  = 1'b1;
                LAD_out = rd_data[3:0];
            end
            RDH: begin
                LAD_oe  = 1'b1;
                LAD_out = rd_data[7:4];
            end
            PTAR1: begin
                LAD_oe  = 1'b1;
                LAD_out = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge LpcClock or posedge rst) begin
        if (rst) begin
            is_write <= 1'b0;
            addr_hi  <= '0;
            wd_lo    <= '0;
            rd_data  <= '0;
            Addr     <= '0;
            DataWr   <= '0;
        end else if (LFRAME_n) begin
            case (state)
                CYC:   is_write      <= (LAD_in == 4'h2);
                ADR3:  addr_hi[11:8] <= LAD_in;
                ADR2:  addr_hi[7:4]  <= LAD_in;
                ADR1:  addr_hi[3:0]  <= LAD_in;
                ADR0:  if (addr_match) Addr <= {3'b000, addr_hi[0], LAD_in};
                WDL:   wd_lo         <= LAD_in;
                WDH:   DataWr        <= {LAD_in, wd_lo};
                // Register file answers one cycle after Rd, i.e. during HTAR2.
                HTAR2: rd_data       <= DataRd;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_io_slave.sv
// Bench for lpc_io_slave: directed vector table, hand-written abort/reset sequences and
// random frames, all checked against a frame-timeline model of the I/O cycle.
module tb_lpc_io_slave;

    localparam logic [15:0] BASE = 16'h0A00;

    logic       LpcClock = 1'b0;
    logic       rst;
    logic       LFRAME_n;
    logic [3:0] LAD_in;
    logic [3:0] LAD_out;
    logic       LAD_oe;
    logic [7:0] Addr;
    logic       Rd;
    logic       Wr;
    logic [7:0] DataWr;
    logic [7:0] DataRd = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rf_mem    [32];
    logic [7:0] model_mem [32];
    logic [7:0] m_addr;
    logic [7:0] m_dwr;

    lpc_io_slave #(.BASE_ADDR(BASE)) dut (
        .LpcClock (LpcClock),
        .rst      (rst),
        .LFRAME_n (LFRAME_n),
        .LAD_in   (LAD_in),
        .LAD_out  (LAD_out),
        .LAD_oe   (LAD_oe),
        .Addr     (Addr),
        .Rd       (Rd),
        .Wr       (Wr),
        .DataWr   (DataWr),
        .DataRd   (DataRd)
    );

    always #15 LpcClock = ~LpcClock;

    // External register file: registered read data, write on strobe.
    always @(posedge LpcClock) begin
        if (Rd) DataRd <= rf_mem[Addr[4:0]];
        if (Wr) rf_mem[Addr[4:0]] <= DataWr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] host_nibble(input int k, input logic [3:0] ctype,
                                               input logic [15:0] a, input logic [7:0] wd);
        case (k)
            0: return 4'h0;
            1: return ctype;
            2: return a[15:12];
            3: return a[11:8];
            4: return a[7:4];
            5: return a[3:0];
            6: return (ctype == 4'h2) ? wd[3:0] : 4'hF;
            7: return (ctype == 4'h2) ? wd[7:4] : 4'hF;
            default: return 4'hF;
        endcase
    endfunction

    // Host drives the first n cycles of a frame with no checking (used for aborts).
    task automatic drive_partial(input logic [3:0] ctype, input logic [15:0] a,
                                 input logic [7:0] wd, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge LpcClock);
            LFRAME_n = (k != 0);
            LAD_in   = host_nibble(k, ctype, a, wd);
        end
    endtask

    // Full frame; cycle k is the clock period k after the START period.
    task automatic run_frame(input logic [3:0] ctype, input logic [15:0] a,
                             input logic [7:0] wd, output bit saw_strobe);
        bit         hit, is_rd, exp_rd, exp_wr, exp_oe;
        logic [3:0] exp_lad;
        logic [7:0] rdv;
        hit        = (ctype == 4'h0 || ctype == 4'h2) && (a[15:5] == BASE[15:5]);
        is_rd      = (ctype == 4'h0);
        rdv        = model_mem[a[4:0]];
        saw_strobe = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge LpcClock);
            exp_rd  = hit && is_rd && (k == 6);
            exp_wr  = hit && !is_rd && (k == 8);
            exp_oe  = hit && (is_rd ? (k >= 8 && k <= 11) : (k == 10 || k == 11));
            exp_lad = 4'hF;
            if (hit && k == (is_rd ? 8 : 10)) exp_lad = 4'h0;
            if (hit && is_rd && k == 9)  exp_lad = rdv[3:0];
            if (hit && is_rd && k == 10) exp_lad = rdv[7:4];
            if (hit && k == 6) m_addr = {3'b000, a[4:0]};
            if (hit && !is_rd && k == 8) m_dwr = wd;

            check($sformatf("rd k=%0d a=%h", k, a),      32'(Rd),      32'(exp_rd));
            check($sformatf("wr k=%0d a=%h", k, a),      32'(Wr),      32'(exp_wr));
            check($sformatf("lad_oe k=%0d a=%h", k, a),  32'(LAD_oe),  32'(exp_oe));
            check($sformatf("lad_out k=%0d a=%h", k, a), 32'(LAD_out), 32'(exp_lad));
            check($sformatf("addr k=%0d a=%h", k, a),    32'(Addr),    32'(m_addr));
            check($sformatf("datawr k=%0d a=%h", k, a),  32'(DataWr),  32'(m_dwr));
            if (Rd || Wr) saw_strobe = 1'b1;
            if (hit && !is_rd && k == 8) model_mem[a[4:0]] = wd;

            LFRAME_n = (k != 0);
            LAD_in   = host_nibble(k, ctype, a, wd);
        end
    endtask

    typedef struct {
        logic [3:0]  ctype;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_dwr;
        bit          exp_strobe;
    } vec_t;

    initial begin
        vec_t       vecs [8];
        bit         strobe;
        logic [3:0] ct;
        logic [15:0] ra;
        logic [7:0] rwd;

        vecs[0] = '{4'h2, 16'h0A04, 8'h5A, 8'h04, 8'h5A, 1'b1};
        vecs[1] = '{4'h0, 16'h0A1F, 8'h00, 8'h1F, 8'h5A, 1'b1};
        vecs[2] = '{4'h2, 16'h0B04, 8'h77, 8'h1F, 8'h5A, 1'b0};
        vecs[3] = '{4'h4, 16'h0A04, 8'h00, 8'h1F, 8'h5A, 1'b0};
        vecs[4] = '{4'h2, 16'h0A1F, 8'h3C, 8'h1F, 8'h3C, 1'b1};
        vecs[5] = '{4'h0, 16'h0A1F, 8'h00, 8'h1F, 8'h3C, 1'b1};
        vecs[6] = '{4'h2, 16'h09FF, 8'h11, 8'h1F, 8'h3C, 1'b0};
        vecs[7] = '{4'h0, 16'h0A20, 8'h00, 8'h1F, 8'h3C, 1'b0};

        for (int i = 0; i < 32; i++) begin
            rf_mem[i]    = 8'($urandom);
            model_mem[i] = rf_mem[i];
        end
        rf_mem[31]    = 8'hC3;
        model_mem[31] = 8'hC3;
        m_addr   = 8'h00;
        m_dwr    = 8'h00;
        rst      = 1'b1;
        LFRAME_n = 1'b1;
        LAD_in   = 4'hF;

        repeat (2) @(negedge LpcClock);
        check("reset rd",      32'(Rd),      32'(0));
        check("reset wr",      32'(Wr),      32'(0));
        check("reset lad_oe",  32'(LAD_oe),  32'(0));
        check("reset lad_out", 32'(LAD_out), 32'(4'hF));
        check("reset addr",    32'(Addr),    32'(8'h00));
        check("reset datawr",  32'(DataWr),  32'(8'h00));
        rst = 1'b0;
        @(negedge LpcClock);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].ctype, vecs[i].a, vecs[i].wd, strobe);
            check($sformatf("vec%0d strobe", i), 32'(strobe), 32'(vecs[i].exp_strobe));
            check($sformatf("vec%0d addr", i),   32'(Addr),   32'(vecs[i].exp_addr));
            check($sformatf("vec%0d datawr", i), 32'(DataWr), 32'(vecs[i].exp_dwr));
        end

        // START during ADR1 of a write aborts it; the restarted read then completes.
        drive_partial(4'h2, 16'h0A06, 8'hEE, 4);
        run_frame(4'h0, 16'h0A07, 8'h00, strobe);
        check("abort_restart strobe", 32'(strobe), 32'(1));
        check("abort_restart addr",   32'(Addr),   32'(8'h07));

        // Abort after HTAR1 of a read: strobe stands, LAD released the next cycle.
        drive_partial(4'h0, 16'h0A05, 8'h00, 9);
        m_addr = 8'h05;
        @(negedge LpcClock);
        check("late_abort oe rdl",  32'(LAD_oe),  32'(1));
        check("late_abort lad rdl", 32'(LAD_out), 32'(model_mem[5][3:0]));
        check("late_abort addr",    32'(Addr),    32'(m_addr));
        LFRAME_n = 1'b0;
        LAD_in   = 4'hF;
        @(negedge LpcClock);
        check("late_abort oe released",  32'(LAD_oe),  32'(0));
        check("late_abort lad released", 32'(LAD_out), 32'(4'hF));
        LFRAME_n = 1'b1;
        @(negedge LpcClock);

        // Reset pulse during SYNC of a read.
        drive_partial(4'h0, 16'h0A10, 8'h00, 8);
        @(negedge LpcClock);
        check("pre_rst sync oe",  32'(LAD_oe),  32'(1));
        check("pre_rst sync lad", 32'(LAD_out), 32'(4'h0));
        rst = 1'b1;
        #1;
        check("rst_sync oe",     32'(LAD_oe),  32'(0));
        check("rst_sync lad",    32'(LAD_out), 32'(4'hF));
        check("rst_sync addr",   32'(Addr),    32'(8'h00));
        check("rst_sync datawr", 32'(DataWr),  32'(8'h00));
        check("rst_sync rd",     32'(Rd),      32'(0));
        m_addr   = 8'h00;
        m_dwr    = 8'h00;
        LFRAME_n = 1'b1;
        LAD_in   = 4'hF;
        @(negedge LpcClock);
        rst = 1'b0;
        run_frame(4'h0, 16'h0A10, 8'h00, strobe);
        check("post_rst read strobe", 32'(strobe), 32'(1));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ct = 4'h0;
                1:       ct = 4'h2;
                default: ct = 4'($urandom);
            endcase
            if ($urandom_range(0, 2) != 0) ra = {BASE[15:5], 5'($urandom)};
            else                           ra = 16'($urandom);
            rwd = 8'($urandom);
            run_frame(ct, ra, rwd, strobe);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
